// File: rtl/car_pkg.sv
// Shared types for the car motor driver: FSM states, command encoding, motor patterns.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package car_pkg;

    // Driver FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3,
        BRAKE  = 3'd4
    } state_t;

    // Command bundle as seen from the steering controller: {front, left, right}
    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE  = 3'b000;
    localparam cmd_t CMD_FRONT = 3'b100;
    localparam cmd_t CMD_LEFT  = 3'b010;
    localparam cmd_t CMD_RIGHT = 3'b001;

    // True when more than one command line is high at once
    function automatic logic cmd_illegal(input cmd_t c);
        return (c[2] & c[1]) | (c[2] & c[0]) | (c[1] & c[0]);
    endfunction

    // H-bridge enables per state, ordered {l_fwd, l_rev, r_fwd, r_rev}.
    // No pattern ever sets fwd and rev of the same wheel together.
    function automatic logic [3:0] motor_pattern(input state_t s);
        case (s)
            FWD:     return 4'b1010;
            TURN_L:  return 4'b0110;
            TURN_R:  return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Largest of three durations; sizes the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/car_dur_timer.sv
// Loadable down-counter timing each manoeuvre and the brake dead-time.
// Latency: load takes effect at the next edge; expired is decoded from the count.
// Backpressure: none; counts every cycle, holds at zero.
module car_dur_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Load on state entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/car_motor_driver.sv
// Wheel H-bridge driver running timed forward/spin manoeuvres, each followed by a brake dead-time.
// Latency: command sampled in IDLE drives motors and busy from that same edge (registered outputs).
// Backpressure: busy high while moving/braking; commands then are dropped, not queued. Optional PWM: CAR_PWM_EN.
module car_motor_driver
    import car_pkg::*;
#(
    parameter int FWD_CYCLES   = 8,
    parameter int TURN_CYCLES  = 4,
    parameter int BRAKE_CYCLES = 2,
    parameter int DUTY         = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_front,
    input  logic go_left,
    input  logic go_right,
    output logic motor_l_fwd,
    output logic motor_l_rev,
    output logic motor_r_fwd,
    output logic motor_r_rev,
    output logic busy,
    output logic cmd_err
);

    localparam int MAX_D = max3(FWD_CYCLES, TURN_CYCLES, BRAKE_CYCLES);
    localparam int TW    = $clog2(MAX_D + 1);

    localparam logic [TW-1:0] FWD_LOAD   = TW'(FWD_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] BRAKE_LOAD = TW'(BRAKE_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    cmd_t            cmd;
    logic            tmr_load;
    logic [TW-1:0]   tmr_load_val;
    logic            tmr_expired;
    logic            err_nxt;
    logic            pwm_on;
    logic [3:0]      motor_nxt;
    logic [3:0]      motor_q;

    assign cmd = {go_front, go_left, go_right};

    car_dur_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

`ifdef CAR_PWM_EN
    logic [3:0] pwm_cnt;
    logic [3:0] pwm_cnt_nxt;

    assign pwm_cnt_nxt = pwm_cnt + 4'd1;

    // Free-running PWM phase, wraps 15 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt_nxt;
        end
    end

    // Compared against the phase the registered outputs will show next cycle
    assign pwm_on = ({1'b0, pwm_cnt_nxt} < 5'(DUTY));
`else
    // Without PWM the forward enables stay on for the whole run (DUTY is always >= 0)
    assign pwm_on = (DUTY >= 0);
`endif

    // Next state and timer reload: sample commands only in IDLE, leave timed states on expiry
    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state)
            IDLE: begin
                case (cmd)
                    CMD_FRONT: begin
                        state_nxt    = FWD;
                        tmr_load     = 1'b1;
                        tmr_load_val = FWD_LOAD;
                    end
                    CMD_LEFT: begin
                        state_nxt    = TURN_L;
                        tmr_load     = 1'b1;
                        tmr_load_val = TURN_LOAD;
                    end
                    CMD_RIGHT: begin
                        state_nxt    = TURN_R;
                        tmr_load     = 1'b1;
                        tmr_load_val = TURN_LOAD;
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
            FWD, TURN_L, TURN_R: begin
                // Every manoeuvre passes through the dead-time before the car can move again
                if (tmr_expired) begin
                    state_nxt    = BRAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = BRAKE_LOAD;
                end
            end
            BRAKE: begin
                if (tmr_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Illegal multi-hot patterns only count when the driver is listening
    assign err_nxt = (state == IDLE) && cmd_illegal(cmd);

    // Motor enables for the coming cycle; PWM gates only the forward run
    always_comb begin
        motor_nxt = motor_pattern(state_nxt);
        if ((state_nxt == FWD) && !pwm_on) begin
            motor_nxt[3] = 1'b0;
            motor_nxt[1] = 1'b0;
        end
    end

    // FSM state and all outputs registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            motor_q <= 4'b0000;
            busy    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            motor_q <= motor_nxt;
            busy    <= (state_nxt != IDLE);
            cmd_err <= err_nxt;
        end
    end

    assign {motor_l_fwd, motor_l_rev, motor_r_fwd, motor_r_rev} = motor_q;

    // A wheel must never be driven both ways at once
    a_l_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(motor_l_fwd && motor_l_rev));
    a_r_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(motor_r_fwd && motor_r_rev));
    // Motors only move while busy
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        !busy |-> (motor_q == 4'b0000));

endmodule

// File: doc/car_motor_driver.md
Name: car_motor_driver

Overview:
- Actuator-side counterpart of the car obstacle controller: consumes its one-hot go_front / go_left / go_right commands and drives the two wheel H-bridges.
- Runs timed manoeuvres (forward run, spin turn), then a brake dead-time, and reports busy back so the controller only issues the next command when the car is idle.
- Sits between the steering controller and the motor pins.

Parameters:
- FWD_CYCLES, 8, clock cycles the forward drive lasts (>=1)
- TURN_CYCLES, 4, clock cycles a spin turn lasts (>=1)
- BRAKE_CYCLES, 2, dead-time cycles with all bridges off after any manoeuvre (>=1)
- DUTY, 12, PWM duty in 1/16ths for forward drive (0..16); used only with CAR_PWM_EN

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- go_front  input  1  command: drive forward
- go_left  input  1  command: spin left
- go_right  input  1  command: spin right
- motor_l_fwd  output  1  left wheel forward enable
- motor_l_rev  output  1  left wheel reverse enable
- motor_r_fwd  output  1  right wheel forward enable
- motor_r_rev  output  1  right wheel reverse enable
- busy  output  1  manoeuvre or brake in progress
- cmd_err  output  1  one-cycle pulse: illegal command pattern sampled

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, counters 0, and all outputs 0 immediately, regardless of the clock, including mid-manoeuvre.
- All outputs are registered. No combinational path runs from inputs to outputs.
- States:
  - IDLE: all motors 0, busy=0.
  - FWD: l_fwd=1, r_fwd=1.
  - TURN_L: l_rev=1, r_fwd=1.
  - TURN_R: l_fwd=1, r_rev=1.
  - BRAKE: all motors 0, busy=1.
- Commands are sampled only in IDLE, at rising edge N.
  - Exactly one go_* high: move to FWD, TURN_L or TURN_R. Motor outputs and busy are high from edge N.
  - None high: stay in IDLE.
  - Two or more high: stay in IDLE and pulse cmd_err=1 for the cycle following edge N. No motion.
- Durations:
  - FWD lasts exactly FWD_CYCLES cycles; TURN_L and TURN_R last exactly TURN_CYCLES cycles.
  - Every manoeuvre is followed by BRAKE for exactly BRAKE_CYCLES cycles, then IDLE.
  - busy is therefore high for FWD_CYCLES+BRAKE_CYCLES cycles (or TURN_CYCLES+BRAKE_CYCLES).
- Turn to brake: the direct transition TURN/FWD -> BRAKE always inserts the dead-time. Fwd and rev of the same wheel are never high in the same cycle.
- Commands asserted while busy=1 are ignored, not queued, and raise no cmd_err.
- Back-to-back commands: a go_* held high is re-sampled on the first IDLE cycle. A new manoeuvre therefore starts one cycle after busy falls.
- Timer:
  - Down-counter loaded with duration-1 on state entry; the state is left when it reads 0.
  - Width is $clog2(max(FWD_CYCLES,TURN_CYCLES,BRAKE_CYCLES)+1).
  - Duration 1 means one cycle in that state.

Optional Feature:
- Macro: CAR_PWM_EN.
- Defined:
  - A 4-bit free-running counter (reset 0, wraps 15->0) gates motor_l_fwd and motor_r_fwd in FWD only. They are high while counter < DUTY.
  - DUTY=16 means always on; DUTY=0 means always off in FWD.
  - Turns and brake are unaffected.
  - busy timing is unchanged.
- Not defined: no counter; FWD drives both fwd enables continuously; DUTY is ignored.

Decomposition:
- Package car_pkg holds:
  - the state enum {IDLE, FWD, TURN_L, TURN_R, BRAKE};
  - the 3-bit command encoding {front,left,right} with the CMD_NONE/CMD_FRONT/CMD_LEFT/CMD_RIGHT constants;
  - the function that flags illegal multi-hot commands.
- Sub-module car_dur_timer holds the loadable down-counter:
  - inputs: load, load_val;
  - output: expired.
- The FSM and output register stay in car_motor_driver.

Test Plan:
- Reset mid-FWD: assert rst_n=0 at cycle 3 of FWD -> all motors and busy 0 at once, without a clock edge; after release, state IDLE.
- go_front pulse for 1 cycle (defaults) -> l_fwd=r_fwd=1 for 8 cycles, then 2 cycles with all 0 and busy=1, then busy=0. Total busy = 10 cycles.
- go_left held high continuously:
  - l_rev=r_fwd=1 for 4 cycles, then 2 brake cycles.
  - Second turn starts one cycle after busy falls.
  - l_fwd and l_rev are never high together.
- Illegal patterns: {front,left,right}=3'b011 sampled in IDLE -> cmd_err high 1 cycle, motors stay 0, busy stays 0. Repeat with 3'b111.
- Commands during busy: during TURN_R, assert go_front for 3 cycles then drop -> ignored; TURN_R completes normally; no cmd_err.
- CAR_PWM_EN defined, DUTY=4, FWD_CYCLES=32 -> in FWD the fwd enables are high for 4 of every 16 cycles; busy still lasts 34 cycles.
